aes_serial_to_parallel_column_assembler: RTL and testbench

- Receive-side counterpart of the MixColumn parallel-to-serial path.
- Accepts an AES state as a byte stream, one byte per handshake, and packs each group of 4 bytes into a 32-bit column.
- Presents each column to the MixColumns/AddRoundKey datapath over a valid/ready handshake.
- Exports the same 4-bit inner_state_counter byte position used by the serializer controller, so both ends share one byte-slot numbering.

---
 rtl/aes_pkg.sv | 16 +
 rtl/aes_byte_slot_counter.sv | 34 +++
 rtl/aes_serial_to_parallel_column_assembler.sv | 111 +++++++++++
 tb/tb_aes_serial_to_parallel_column_assembler.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES datapath constants, byte/column types and the column assembler FSM state encoding.
package aes_pkg;

  localparam int AES_BYTE_W   = 8;
  localparam int AES_COL_W    = 32;
  localparam int AES_NUM_COLS = 4;

  typedef logic [AES_BYTE_W-1:0] aes_byte_t;
  typedef logic [AES_COL_W-1:0]  aes_col_t;

  typedef enum logic {
    S2P_FILL = 1'b0,
    S2P_HOLD = 1'b1
  } s2p_state_e;

endpackage

// File: rtl/aes_byte_slot_counter.sv
// Modulo-16 byte-slot counter shared by the AES serializer and deserializer controllers.
// A load takes priority over an increment; 15 -> 0 wraps silently.
module aes_byte_slot_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic [3:0] count
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (inc) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/aes_serial_to_parallel_column_assembler.sv
// Packs an AES byte stream into 32-bit columns (first byte in the MSBs) and hands them out over valid/ready.
// Optional block-framing resync on in_first is enabled by defining AES_S2P_SYNC_CHECK_EN.
module aes_serial_to_parallel_column_assembler
  import aes_pkg::*;
#(
  parameter int BYTE_W         = AES_BYTE_W,
  parameter int BYTES_PER_COL  = AES_COL_W / AES_BYTE_W,
  parameter int COLS_PER_BLOCK = AES_NUM_COLS
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [BYTE_W-1:0]               in_byte,
  input  logic                            in_first,
  output logic                            col_valid,
  input  logic                            col_ready,
  output logic [BYTE_W*BYTES_PER_COL-1:0] col_data,
  output logic [1:0]                      col_index,
  output logic                            col_last,
  output logic [3:0]                      inner_state_counter,
  output logic                            sync_err,
  output s2p_state_e                      state_dbg
);

  localparam int COL_W = BYTE_W * BYTES_PER_COL;

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
  // A producer keeps valid and its payload stable until that edge; ready may be anything.

  s2p_state_e       state_q, state_d;
  logic [COL_W-1:0] col_shift_q, col_shift_d;
  logic [1:0]       col_index_q, col_index_d;
  logic             sync_err_q, sync_err_d;

  logic       accept;
  logic       resync;
  logic [3:0] slot_cnt;

  assign in_ready = (state_q == S2P_FILL);
  assign accept   = in_valid && in_ready;

`ifdef AES_S2P_SYNC_CHECK_EN
  assign resync = accept && in_first && (slot_cnt != 4'd0);
`else
  logic unused_in_first;
  assign unused_in_first = in_first;
  assign resync          = 1'b0;
`endif

  aes_byte_slot_counter u_slot_cnt (
    .clk      (clk),
    .rst      (rst),
    .inc      (accept && !resync),
    .load     (resync),
    .load_val (4'd1),
    .count    (slot_cnt)
  );

  always_comb begin
    state_d     = state_q;
    col_shift_d = col_shift_q;
    col_index_d = col_index_q;
    sync_err_d  = 1'b0;
    case (state_q)
      S2P_FILL: begin
        if (resync) begin
          // The resync byte restarts column 0; whatever was partially packed is dropped.
          col_shift_d = {{(COL_W-BYTE_W){1'b0}}, in_byte};
          sync_err_d  = 1'b1;
        end else if (accept) begin
          col_shift_d = {col_shift_q[COL_W-BYTE_W-1:0], in_byte};
          if (slot_cnt[1:0] == 2'd3) begin
            state_d     = S2P_HOLD;
            col_index_d = slot_cnt[3:2];
          end
        end
      end
      S2P_HOLD: begin
        if (col_ready) begin
          state_d = S2P_FILL;
        end
      end
      default: state_d = S2P_FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S2P_FILL;
      col_shift_q <= '0;
      col_index_q <= 2'd0;
      sync_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_shift_q <= col_shift_d;
      col_index_q <= col_index_d;
      sync_err_q  <= sync_err_d;
    end
  end

  // Column outputs read as zero outside HOLD so a partial column is never visible.
  assign col_valid           = (state_q == S2P_HOLD);
  assign col_data            = col_valid ? col_shift_q : '0;
  assign col_index           = col_valid ? col_index_q : 2'd0;
  assign col_last            = col_valid && (col_index_q == 2'(COLS_PER_BLOCK - 1));
  assign inner_state_counter = slot_cnt;
  assign sync_err            = sync_err_q;
  assign state_dbg           = state_q;

endmodule

// File: tb/tb_aes_serial_to_parallel_column_assembler.sv
// Directed self-checking bench for the AES serial-to-parallel column assembler.
module tb_aes_serial_to_parallel_column_assembler;
  import aes_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_byte;
  logic        in_first;
  logic        col_valid;
  logic        col_ready;
  logic [31:0] col_data;
  logic [1:0]  col_index;
  logic        col_last;
  logic [3:0]  inner_state_counter;
  logic        sync_err;
  s2p_state_e  state_dbg;

  int n_tests;
  int n_fail;
  logic [31:0] exp_q[$];

  aes_serial_to_parallel_column_assembler dut (
    .clk                 (clk),
    .rst                 (rst),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .in_byte             (in_byte),
    .in_first            (in_first),
    .col_valid           (col_valid),
    .col_ready           (col_ready),
    .col_data            (col_data),
    .col_index           (col_index),
    .col_last            (col_last),
    .inner_state_counter (inner_state_counter),
    .sync_err            (sync_err),
    .state_dbg           (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- drivers (called at a negedge, return at a negedge) ----------------
  task automatic send_byte(input logic [7:0] b, input logic first);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 32'd0, 32'd1);
    in_valid = 1'b1;
    in_byte  = b;
    in_first = first;
    @(negedge clk);
    in_valid = 1'b0;
    in_first = 1'b0;
  endtask

  task automatic send_col(input logic [31:0] c);
    for (int i = 3; i >= 0; i--) send_byte(c[i*8 +: 8], 1'b0);
  endtask

  // Scoreboard consumer: pops the expected column and checks it, then completes the handshake.
  task automatic take_col(input string tag, input logic [1:0] exp_idx);
    int n;
    logic [31:0] exp_col;
    n = 0;
    while (!col_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, 32'(col_valid), 32'd1);
    exp_col = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
    check({tag, "_data"}, col_data, exp_col);
    check({tag, "_index"}, 32'(col_index), 32'(exp_idx));
    check({tag, "_last"}, 32'(col_last), 32'(exp_idx == 2'd3));
    col_ready = 1'b1;
    @(negedge clk);
    col_ready = 1'b0;
    check({tag, "_in_ready_after"}, 32'(in_ready), 32'd1);
    check({tag, "_valid_after"}, 32'(col_valid), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_byte   = 8'h00;
    in_first  = 1'b0;
    col_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_col_valid", 32'(col_valid), 32'd0);
    check("rst_col_data", col_data, 32'd0);
    check("rst_col_index", 32'(col_index), 32'd0);
    check("rst_col_last", 32'(col_last), 32'd0);
    check("rst_counter", 32'(inner_state_counter), 32'd0);
    check("rst_sync_err", 32'(sync_err), 32'd0);

    // Test 1: one column, valid one cycle after the 4th accept
    send_col(32'h3243F6A8);
    exp_q.push_back(32'h3243F6A8);
    check("t1_in_ready", 32'(in_ready), 32'd0);
    check("t1_counter", 32'(inner_state_counter), 32'd4);
    take_col("t1", 2'd0);

    // Test 2: full block 0x00..0x0F, counter wraps
    do_reset();
    for (int c = 0; c < 4; c++) begin
      logic [31:0] col;
      col = {8'(4*c), 8'(4*c+1), 8'(4*c+2), 8'(4*c+3)};
      exp_q.push_back(col);
      send_col(col);
      take_col($sformatf("t2_col%0d", c), 2'(c));
    end
    check("t2_counter_wrap", 32'(inner_state_counter), 32'd0);

    // Test 3: backpressure for 10 cycles while a byte is offered
    do_reset();
    send_col(32'h11223344);
    exp_q.push_back(32'h11223344);
    in_valid = 1'b1;
    in_byte  = 8'h55;
    for (int i = 0; i < 10; i++) begin
      check("t3_hold_data", col_data, 32'h11223344);
      check("t3_hold_in_ready", 32'(in_ready), 32'd0);
      check("t3_hold_counter", 32'(inner_state_counter), 32'd4);
      @(negedge clk);
    end
    in_valid = 1'b0;
    take_col("t3", 2'd0);
    check("t3_counter_after", 32'(inner_state_counter), 32'd4);

    // Test 4: gap inside a column; col_ready in FILL must be ignored
    do_reset();
    send_byte(8'hDE, 1'b0);
    send_byte(8'hAD, 1'b0);
    col_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t4_gap_counter", 32'(inner_state_counter), 32'd2);
      check("t4_gap_valid", 32'(col_valid), 32'd0);
    end
    col_ready = 1'b0;
    send_byte(8'hBE, 1'b0);
    send_byte(8'hEF, 1'b0);
    exp_q.push_back(32'hDEADBEEF);
    take_col("t4", 2'd0);

    // Test 5: asynchronous reset mid-column discards the partial column
    send_byte(8'hF0, 1'b0);
    send_byte(8'hF1, 1'b0);
    check("t5_pre_counter", 32'(inner_state_counter), 32'd6);
    #2;
    rst = 1'b1;
    #1;
    check("t5_async_counter", 32'(inner_state_counter), 32'd0);
    check("t5_async_valid", 32'(col_valid), 32'd0);
    check("t5_async_data", col_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    send_col(32'h01020304);
    exp_q.push_back(32'h01020304);
    take_col("t5", 2'd0);

    // Test 6: in_first on the 3rd byte
    do_reset();
    send_byte(8'hA1, 1'b0);
    send_byte(8'hA2, 1'b0);
    send_byte(8'hAA, 1'b1);
`ifdef AES_S2P_SYNC_CHECK_EN
    check("t6_sync_err_pulse", 32'(sync_err), 32'd1);
    check("t6_counter_resync", 32'(inner_state_counter), 32'd1);
    send_byte(8'hB1, 1'b0);
    check("t6_sync_err_drop", 32'(sync_err), 32'd0);
    send_byte(8'hB2, 1'b0);
    send_byte(8'hB3, 1'b0);
    exp_q.push_back(32'hAAB1B2B3);
    take_col("t6", 2'd0);
    check("t6_counter_end", 32'(inner_state_counter), 32'd4);
`else
    check("t6_no_sync_err", 32'(sync_err), 32'd0);
    check("t6_counter_normal", 32'(inner_state_counter), 32'd3);
    send_byte(8'hB1, 1'b0);
    check("t6_no_sync_err_late", 32'(sync_err), 32'd0);
    exp_q.push_back(32'hA1A2AAB1);
    take_col("t6", 2'd0);
    check("t6_counter_end", 32'(inner_state_counter), 32'd4);
`endif

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
